// File: rtl/rpn_ctrl.sv
// rpn_ctrl: reverse-Polish evaluation controller in front of a LIFO stack.
// Operands are pushed; a binary operator pops B (top) then A, pushes
// R = A op B and reports R on res_data with a one-cycle res_valid pulse.
// Depth is tracked locally so the stack never sees an illegal push or pop;
// overflow, underflow and bad opcodes raise sticky flags instead.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | tok_ready high, decode and accept/reject one token
// S_PUSH  | stk_push high for a latched operand
// S_POP_B | stk_pop high, capture top entry as B
// S_POP_A | stk_pop high, top entry is A, compute R for the next cycle
// S_CALC  | stk_push high with R, res_valid pulse
module rpn_ctrl #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic                  tok_is_op,
  input  logic [WIDTH-1:0]      tok_data,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [WIDTH-1:0]      stk_wdata,
  input  logic [WIDTH-1:0]      stk_top,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic                  err_ovf,
  output logic                  err_udf,
  output logic                  err_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_B,
    S_POP_A,
    S_CALC
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_MAX = ADDR_WIDTH'(HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_TWO = ADDR_WIDTH'(2);

  state_t                  state_q;
  logic                    ready_q;
  logic                    push_q;
  logic                    pop_q;
  logic [WIDTH-1:0]        wdata_q;
  logic                    res_valid_q;
  logic [WIDTH-1:0]        res_data_q;
  logic [ADDR_WIDTH-1:0]   depth_q;
  logic                    err_ovf_q;
  logic                    err_udf_q;
  logic                    err_op_q;
  logic [2:0]              op_q;
  logic [WIDTH-1:0]        b_q;
  logic [WIDTH-1:0]        calc_d;
  logic                    tok_accept;

  // Wrapping ALU; opcodes 6/7 are rejected before they ever reach here.
  function automatic logic [WIDTH-1:0] alu(input logic [2:0]       op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // In POP_A the stack top is operand A; B was captured one cycle earlier.
  always_comb begin
    calc_d = alu(op_q, stk_top, b_q);
  end

  assign tok_accept = tok_valid & ready_q;

  // Sequencer: all outputs are registered here, nothing combinational from tok_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      depth_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
      err_op_q    <= 1'b0;
      op_q        <= '0;
      b_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tok_accept) begin
            if (!tok_is_op) begin
              if (depth_q == DEPTH_MAX) begin
                err_ovf_q <= 1'b1;
              end else begin
                wdata_q <= tok_data;
                push_q  <= 1'b1;
                ready_q <= 1'b0;
                state_q <= S_PUSH;
              end
            end else if (tok_data[2:1] == 2'b11) begin
              err_op_q <= 1'b1;
            end else if (depth_q < DEPTH_TWO) begin
              err_udf_q <= 1'b1;
            end else begin
              op_q    <= tok_data[2:0];
              pop_q   <= 1'b1;
              ready_q <= 1'b0;
              state_q <= S_POP_B;
            end
          end else begin
            // Also raises ready on the first cycle out of reset.
            ready_q <= 1'b1;
          end
        end
        S_PUSH: begin
          push_q  <= 1'b0;
          depth_q <= depth_q + DEPTH_ONE;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_POP_B: begin
          b_q     <= stk_top;
          depth_q <= depth_q - DEPTH_ONE;
          state_q <= S_POP_A;
        end
        S_POP_A: begin
          pop_q       <= 1'b0;
          depth_q     <= depth_q - DEPTH_ONE;
          push_q      <= 1'b1;
          wdata_q     <= calc_d;
          res_data_q  <= calc_d;
          res_valid_q <= 1'b1;
          state_q     <= S_CALC;
        end
        S_CALC: begin
          push_q      <= 1'b0;
          res_valid_q <= 1'b0;
          depth_q     <= depth_q + DEPTH_ONE;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tok_ready = ready_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_wdata = wdata_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign depth     = depth_q;
  assign err_ovf   = err_ovf_q;
  assign err_udf   = err_udf_q;
  assign err_op    = err_op_q;

endmodule

// File: tb/tb_rpn_ctrl.sv
// Testbench for rpn_ctrl: a LIFO stack environment plus a queue-based RPN
// reference model; directed scenarios followed by random token streams.
module tb_rpn_ctrl;
  localparam int W  = 8;
  localparam int H  = 9;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_is_op = 1'b0;
  logic [W-1:0]  tok_data = '0;
  logic          stk_push;
  logic          stk_pop;
  logic [W-1:0]  stk_wdata;
  logic [W-1:0]  stk_top;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic [AW-1:0] depth;
  logic          err_ovf;
  logic          err_udf;
  logic          err_op;

  always #5 clk = ~clk;

  rpn_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_top(stk_top),
    .res_valid(res_valid), .res_data(res_data),
    .depth(depth),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_op(err_op)
  );

  // Downstream stack: registered data_out, cleared by the shared rst.
  logic [W-1:0] smem [0:H-1];
  int sp;
  int push_cnt, pop_cnt, res_cnt, bad_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else begin
      if (stk_push && stk_pop) begin
        bad_cnt <= bad_cnt + 1;
      end else if (stk_push) begin
        push_cnt <= push_cnt + 1;
        if (sp >= H) bad_cnt <= bad_cnt + 1;
        else begin
          smem[sp] <= stk_wdata;
          sp <= sp + 1;
        end
      end else if (stk_pop) begin
        pop_cnt <= pop_cnt + 1;
        if (sp == 0) bad_cnt <= bad_cnt + 1;
        else sp <= sp - 1;
      end
      if (res_valid) res_cnt <= res_cnt + 1;
    end
  end

  assign stk_top = (sp > 0) ? smem[sp-1] : '0;

  // Reference model state.
  logic [W-1:0] ref_q[$];
  logic         e_ovf, e_udf, e_op;
  logic [W-1:0] e_res;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] ref_calc(int op, int a, int b);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      3:       r = a | b;
      4:       r = a ^ b;
      default: r = a * b;
    endcase
    return W'(r & ((1 << W) - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".ready"},   32'(tok_ready), 0);
    chk({tag, ".push"},    32'(stk_push),  0);
    chk({tag, ".pop"},     32'(stk_pop),   0);
    chk({tag, ".wdata"},   32'(stk_wdata), 0);
    chk({tag, ".rvalid"},  32'(res_valid), 0);
    chk({tag, ".rdata"},   32'(res_data),  0);
    chk({tag, ".depth"},   32'(depth),     0);
    chk({tag, ".errs"},    32'({err_ovf, err_udf, err_op}), 0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".depth"}, 32'(depth), 32'(ref_q.size()));
    chk({tag, ".errs"},  32'({err_ovf, err_udf, err_op}), 32'({e_ovf, e_udf, e_op}));
    chk({tag, ".rdata"}, 32'(res_data), 32'(e_res));
    if (ref_q.size() > 0) chk({tag, ".top"}, 32'(stk_top), 32'(ref_q[$]));
  endtask

  task automatic model_clear();
    ref_q.delete();
    e_ovf = 0; e_udf = 0; e_op = 0;
    e_res = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tok_valid = 1'b0;
    #1;
    chk_zero_outputs("rst_async");
    @(negedge clk);
    chk_zero_outputs("rst_held");
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_rel.ready", 32'(tok_ready), 1);
    chk("rst_rel.depth", 32'(depth), 0);
  endtask

  // One token, checked cycle by cycle against the spec timing.
  task automatic do_token(input bit is_op, input logic [W-1:0] d);
    int p0, q0, r0, n, op;
    logic [W-1:0] a, b, r;
    @(negedge clk);
    chk("tok.ready", 32'(tok_ready), 1);
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
    p0 = push_cnt; q0 = pop_cnt; r0 = res_cnt; n = ref_q.size();
    @(negedge clk);                       // cycle E+1
    tok_valid = 1'b0;
    op = int'(d[2:0]);
    if (!is_op && n == H) begin
      e_ovf = 1;
      chk("ovf.ready",   32'(tok_ready), 1);
      chk("ovf.nopush",  32'(push_cnt - p0), 0);
      chk("ovf.pushlvl", 32'(stk_push), 0);
    end else if (!is_op) begin
      ref_q.push_back(d);
      chk("opnd.push",  32'(stk_push), 1);
      chk("opnd.pop",   32'(stk_pop), 0);
      chk("opnd.wdata", 32'(stk_wdata), 32'(d));
      chk("opnd.busy",  32'(tok_ready), 0);
      @(negedge clk);                     // cycle E+2
      chk("opnd.ready2", 32'(tok_ready), 1);
      chk("opnd.push2",  32'(stk_push), 0);
    end else if (op >= 6) begin
      e_op = 1;
      chk("badop.ready", 32'(tok_ready), 1);
      chk("badop.stk",   32'((push_cnt - p0) + (pop_cnt - q0) + int'(stk_push) + int'(stk_pop)), 0);
    end else if (n < 2) begin
      e_udf = 1;
      chk("udf.ready", 32'(tok_ready), 1);
      chk("udf.stk",   32'((push_cnt - p0) + (pop_cnt - q0) + int'(stk_push) + int'(stk_pop)), 0);
    end else begin
      b = ref_q.pop_back();
      a = ref_q.pop_back();
      r = ref_calc(op, int'(a), int'(b));
      ref_q.push_back(r);
      chk("op.popB",   32'(stk_pop), 1);
      chk("op.depthB", 32'(depth), 32'(n));
      @(negedge clk);                     // cycle E+2
      chk("op.popA",   32'(stk_pop), 1);
      chk("op.depthA", 32'(depth), 32'(n - 1));
      @(negedge clk);                     // cycle E+3
      chk("op.rvalid", 32'(res_valid), 1);
      chk("op.rdata",  32'(res_data), 32'(r));
      chk("op.push",   32'({stk_push, stk_pop}), 32'(2'b10));
      chk("op.wdata",  32'(stk_wdata), 32'(r));
      chk("op.depthC", 32'(depth), 32'(n - 2));
      e_res = r;
      @(negedge clk);                     // cycle E+4
      chk("op.ready",  32'(tok_ready), 1);
      chk("op.pulse",  32'(res_cnt - r0), 1);
      chk("op.rvalid0", 32'(res_valid), 0);
    end
    chk_state("post");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rcnt;
    model_clear();
    // Reset and idle
    do_reset();

    // Add: 5 + 3
    do_token(0, 8'd5);
    do_token(0, 8'd3);
    do_token(1, 8'd0);
    chk("add.res", 32'(res_data), 8);
    chk("add.top", 32'(stk_top), 8);
    chk("add.depth", 32'(depth), 1);

    // Reset mid-run clears everything
    do_reset();

    // Subtract wrap then multiply truncation
    do_token(0, 8'd3);
    do_token(0, 8'd5);
    do_token(1, 8'd1);
    chk("sub.res", 32'(res_data), 32'h00FE);
    do_token(0, 8'h10);
    do_token(1, 8'd5);
    chk("mul.res", 32'(res_data), 32'h00E0);

    // Overflow
    do_reset();
    for (int i = 0; i < H; i++) do_token(0, W'(i + 1));
    do_token(0, 8'hAA);
    chk("ovf.flag", 32'(err_ovf), 1);
    chk("ovf.depth", 32'(depth), 9);

    // Underflow and bad opcode
    do_reset();
    do_token(0, 8'd1);
    do_token(1, 8'd2);
    chk("udf.flag", 32'(err_udf), 1);
    chk("udf.depth", 32'(depth), 1);
    do_token(1, 8'd7);
    chk("badop.flag", 32'(err_op), 1);

    // Reset during POP_A
    do_reset();
    do_token(0, 8'd1);
    do_token(0, 8'd2);
    rcnt = res_cnt;
    @(negedge clk);
    tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'd0;
    @(negedge clk);                       // POP_B
    tok_valid = 1'b0;
    @(negedge clk);                       // POP_A
    chk("midop.inPopA", 32'(stk_pop), 1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("midop.rst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("midop.nores", 32'(res_cnt - rcnt), 0);
    chk("midop.depth", 32'(depth), 0);
    chk("midop.idle",  32'(tok_ready), 1);
    do_token(0, 8'h42);

    // Random token streams
    do_reset();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) < 4)
        do_token(1, W'($urandom_range(0, 7)));
      else
        do_token(0, W'($urandom));
    end

    @(negedge clk);
    chk("stack.illegal", 32'(bad_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
